// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: hc/vc counters, pixel-request stage S1, pin stage S2.
// Defining VGA_TEST_PATTERN_EN adds the pattern_en input and an 8-bar colour test pattern.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 128,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 9,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 28,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 1,
    parameter int unsigned CNT_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3*CW-1:0]   color_px,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              pattern_en,
`endif
    output logic [CNT_W-1:0]  x_px,
    output logic [CNT_W-1:0]  y_px,
    output logic              px_req,
    output logic              line_start,
    output logic              frame_start,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [CW-1:0]     red,
    output logic [CW-1:0]     green,
    output logic [CW-1:0]     blue
);

    localparam int unsigned HBLANK = H_FP + H_SYNC + H_BP;
    localparam int unsigned HTOTAL = HBLANK + H_ACTIVE;
    localparam int unsigned VBLANK = V_FP + V_SYNC + V_BP;
    localparam int unsigned VTOTAL = VBLANK + V_ACTIVE;
    localparam int unsigned HS_END = H_FP + H_SYNC;
    localparam int unsigned VS_END = V_FP + V_SYNC;

    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;
    logic             hc_last;
    logic             vc_last;
    logic             hs_raw;
    logic             vs_raw;
    logic             vis;
    logic             h_first;
    logic             v_first;
    logic             s1_hs;
    logic             s1_vs;
    logic [3*CW-1:0]  rgb_sel;

    // Raw decode of the counters
    always_comb begin
        hc_last = (hc == CNT_W'(HTOTAL - 1));
        vc_last = (vc == CNT_W'(VTOTAL - 1));
        hs_raw  = (hc >= CNT_W'(H_FP)) && (hc < CNT_W'(HS_END));
        vs_raw  = (vc >= CNT_W'(V_FP)) && (vc < CNT_W'(VS_END));
        vis     = (hc >= CNT_W'(HBLANK)) && (vc >= CNT_W'(VBLANK));
        h_first = (hc == CNT_W'(HBLANK));
        v_first = (vc == CNT_W'(VBLANK));
    end

    // Line and frame counters; vc advances on the hc wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            hc <= '0;
            vc <= '0;
        end else if (hc_last) begin
            hc <= '0;
            vc <= vc_last ? '0 : vc + CNT_W'(1);
        end else begin
            hc <= hc + CNT_W'(1);
        end
    end

    // S1: pixel request, coordinates and markers; px_req doubles as the carried vis
    always_ff @(posedge clk) begin
        if (rst) begin
            px_req      <= 1'b0;
            x_px        <= '0;
            y_px        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            s1_hs       <= 1'b0;
            s1_vs       <= 1'b0;
        end else begin
            px_req      <= vis;
            x_px        <= vis ? hc - CNT_W'(HBLANK) : '0;
            y_px        <= vis ? vc - CNT_W'(VBLANK) : '0;
            line_start  <= vis && h_first;
            frame_start <= vis && h_first && v_first;
            s1_hs       <= hs_raw;
            s1_vs       <= vs_raw;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;

    // Eight equal-width vertical bars across the active line
    always_comb begin
        bar     = 3'(x_px / CNT_W'(H_ACTIVE / 8));
        rgb_sel = pattern_en ? {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}} : color_px;
    end
`else
    always_comb begin
        rgb_sel = color_px;
    end
`endif

    // S2: sync, de and colour leave the same register so they cannot skew
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync              <= ~HS_POL;
            vsync              <= ~VS_POL;
            de                 <= 1'b0;
            {red, green, blue} <= '0;
        end else begin
            hsync              <= s1_hs ? HS_POL : ~HS_POL;
            vsync              <= s1_vs ? VS_POL : ~VS_POL;
            de                 <= px_req;
            {red, green, blue} <= px_req ? rgb_sel : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a reduced 64x8 raster, active-low DUT and active-high DUT.
// Expected S1 and pin values are queued per cycle from a behavioural counter model.
module tb_vga_timing_gen;

    localparam int H_ACTIVE = 64;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 8;
    localparam int H_BP     = 12;
    localparam int V_ACTIVE = 8;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int CW       = 1;
    localparam int CNT_W    = 10;
    localparam int HBLANK   = H_FP + H_SYNC + H_BP;
    localparam int HTOTAL   = HBLANK + H_ACTIVE;
    localparam int VBLANK   = V_FP + V_SYNC + V_BP;
    localparam int VTOTAL   = VBLANK + V_ACTIVE;
    localparam int FRAME    = HTOTAL * VTOTAL;

    // {hs0,vs0,de0,rgb0,hs1,vs1,de1,rgb1} at reset: active-low idles high, active-high idles low
    localparam logic [11:0] PIN_RST = 12'b110_000_000_000;

    logic             clk;
    logic             rst;
    logic [3*CW-1:0]  color0, color1;
    logic [CNT_W-1:0] x0, y0, x1, y1;
    logic             px_req0, ls0, fs0, hs0, vs0, de0;
    logic             px_req1, ls1, fs1, hs1, vs1, de1;
    logic [CW-1:0]    r0, g0, b0, r1, g1, b1;

    int            mhc, mvc;
    logic [45:0]   q1[$];
    logic [11:0]   q2[$];
    int            n_cmp, n_bad;

    // Pixel sources: one clock of combinational lookup from the request coordinates
    assign color0 = x0[2:0];
`ifdef VGA_TEST_PATTERN_EN
    logic pattern_en;
    assign pattern_en = 1'b1;
    assign color1 = ~x1[5:3];
`else
    assign color1 = x1[5:3];
`endif

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .CNT_W(CNT_W)
    ) dut0 (
        .clk(clk), .rst(rst), .color_px(color0),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_en(1'b0),
`endif
        .x_px(x0), .y_px(y0), .px_req(px_req0), .line_start(ls0), .frame_start(fs0),
        .hsync(hs0), .vsync(vs0), .de(de0), .red(r0), .green(g0), .blue(b0)
    );

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW), .CNT_W(CNT_W)
    ) dut1 (
        .clk(clk), .rst(rst), .color_px(color1),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_en(pattern_en),
`endif
        .x_px(x1), .y_px(y1), .px_req(px_req1), .line_start(ls1), .frame_start(fs1),
        .hsync(hs1), .vsync(vs1), .de(de1), .red(r1), .green(g1), .blue(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic restart_model();
        q1.delete();
        q2.delete();
        q1.push_back('0);
        q2.push_back(PIN_RST);
        q2.push_back(PIN_RST);
        mhc = 0;
        mvc = 0;
    endtask

    // Push this cycle's expectations, pop the ones due now, sample the DUTs, advance a cycle
    task automatic tick(output logic [45:0] s1_a, output logic [45:0] s1_e,
                        output logic [11:0] p_a, output logic [11:0] p_e);
        logic hs, vs, vis, ls, fs;
        logic [CNT_W-1:0] x, y;
        logic [22:0] s1;
        hs  = (mhc >= H_FP) && (mhc < H_FP + H_SYNC);
        vs  = (mvc >= V_FP) && (mvc < V_FP + V_SYNC);
        vis = (mhc >= HBLANK) && (mvc >= VBLANK);
        x   = vis ? CNT_W'(mhc - HBLANK) : '0;
        y   = vis ? CNT_W'(mvc - VBLANK) : '0;
        ls  = vis && (mhc == HBLANK);
        fs  = ls && (mvc == VBLANK);
        s1  = {vis, ls, fs, x, y};
        q1.push_back({s1, s1});
        q2.push_back({~hs, ~vs, vis, vis ? x[2:0] : 3'b000,
                       hs, vs, vis, vis ? x[5:3] : 3'b000});
        s1_e = q1.pop_front();
        p_e  = q2.pop_front();
        s1_a = {px_req0, ls0, fs0, x0, y0, px_req1, ls1, fs1, x1, y1};
        p_a  = {hs0, vs0, de0, r0, g0, b0, hs1, vs1, de1, r1, g1, b1};
        if (mhc == HTOTAL - 1) begin
            mhc = 0;
            mvc = (mvc == VTOTAL - 1) ? 0 : mvc + 1;
        end else begin
            mhc = mhc + 1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({hs0, vs0, de0, r0, g0, b0, hs1, vs1, de1, r1, g1, b1} !== PIN_RST) begin
                n_bad++;
                $display("FAIL reset_pins cyc=%0d got=%h exp=%h", i,
                         {hs0, vs0, de0, r0, g0, b0, hs1, vs1, de1, r1, g1, b1}, PIN_RST);
            end
            n_cmp++;
            if ({px_req0, ls0, fs0, x0, y0, px_req1, ls1, fs1, x1, y1} !== 46'd0) begin
                n_bad++;
                $display("FAIL reset_s1 cyc=%0d got=%h exp=0", i,
                         {px_req0, ls0, fs0, x0, y0, px_req1, ls1, fs1, x1, y1});
            end
        end
        rst = 1'b0;
        restart_model();
    endtask

    task automatic test_timing();
        logic [45:0] s1_a, s1_e;
        logic [11:0] p_a, p_e;
        logic ph, pv, pd;
        int hfall, hlow, vfall, drise, n_ls, n_fs, n_lines;
        ph = 1'b1; pv = 1'b1; pd = 1'b0;
        hfall = -1; hlow = -1; vfall = -1; drise = -1;
        n_ls = 0; n_fs = 0; n_lines = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick(s1_a, s1_e, p_a, p_e);
            n_cmp++;
            if (s1_a !== s1_e) begin
                n_bad++;
                $display("FAIL s1_stage cyc=%0d got=%h exp=%h", k, s1_a, s1_e);
            end
            n_cmp++;
            if (p_a !== p_e) begin
                n_bad++;
                $display("FAIL pins cyc=%0d got=%h exp=%h", k, p_a, p_e);
            end
            if (ph && !p_a[11]) begin
                n_cmp++;
                if (hfall < 0 ? (k !== 2 + H_FP) : (k - hfall !== HTOTAL)) begin
                    n_bad++;
                    $display("FAIL hsync_fall cyc=%0d got=%0d exp=%0d", k,
                             hfall < 0 ? k : k - hfall, hfall < 0 ? 2 + H_FP : HTOTAL);
                end
                hfall = k;
                hlow  = k;
            end
            if (!ph && p_a[11]) begin
                n_cmp++;
                if (k - hlow !== H_SYNC) begin
                    n_bad++;
                    $display("FAIL hsync_width cyc=%0d got=%0d exp=%0d", k, k - hlow, H_SYNC);
                end
            end
            if (pv && !p_a[10]) begin
                n_cmp++;
                if (vfall < 0 ? (k !== 2 + V_FP * HTOTAL) : (k - vfall !== FRAME)) begin
                    n_bad++;
                    $display("FAIL vsync_fall cyc=%0d got=%0d exp=%0d", k,
                             vfall < 0 ? k : k - vfall, vfall < 0 ? 2 + V_FP * HTOTAL : FRAME);
                end
                vfall = k;
            end
            if (!pv && p_a[10]) begin
                n_cmp++;
                if (k - vfall !== V_SYNC * HTOTAL) begin
                    n_bad++;
                    $display("FAIL vsync_width cyc=%0d got=%0d exp=%0d", k, k - vfall,
                             V_SYNC * HTOTAL);
                end
            end
            if (!pd && p_a[9]) begin
                drise = k;
                n_lines++;
            end
            if (pd && !p_a[9]) begin
                n_cmp++;
                if (k - drise !== H_ACTIVE) begin
                    n_bad++;
                    $display("FAIL de_width cyc=%0d got=%0d exp=%0d", k, k - drise, H_ACTIVE);
                end
            end
            if (s1_a[44]) n_ls++;
            if (s1_a[43]) n_fs++;
            ph = p_a[11]; pv = p_a[10]; pd = p_a[9];
        end
        n_cmp++;
        if (n_ls !== 2 * V_ACTIVE) begin
            n_bad++;
            $display("FAIL line_start_count got=%0d exp=%0d", n_ls, 2 * V_ACTIVE);
        end
        n_cmp++;
        if (n_fs !== 2) begin
            n_bad++;
            $display("FAIL frame_start_count got=%0d exp=2", n_fs);
        end
        n_cmp++;
        if (n_lines !== 2 * V_ACTIVE) begin
            n_bad++;
            $display("FAIL de_line_count got=%0d exp=%0d", n_lines, 2 * V_ACTIVE);
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [45:0] s1_a, s1_e;
        logic [11:0] p_a, p_e;
        logic found, ph;
        int hfall;
        found = 1'b0;
        for (int k = 0; k < FRAME && !found; k++) begin
            if (mvc == 9 && mhc == 30) begin
                found = 1'b1;
            end else begin
                tick(s1_a, s1_e, p_a, p_e);
                n_cmp++;
                if ({s1_a, p_a} !== {s1_e, p_e}) begin
                    n_bad++;
                    $display("FAIL pre_reset cyc=%0d got=%h exp=%h", k, {s1_a, p_a}, {s1_e, p_e});
                end
            end
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL mid_reset_point got=not_reached exp=vc9_hc30");
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({hs0, vs0, de0, r0, g0, b0, hs1, vs1, de1, r1, g1, b1} !== PIN_RST) begin
            n_bad++;
            $display("FAIL mid_reset_pins got=%h exp=%h",
                     {hs0, vs0, de0, r0, g0, b0, hs1, vs1, de1, r1, g1, b1}, PIN_RST);
        end
        n_cmp++;
        if ({px_req0, ls0, fs0, x0, y0, px_req1, ls1, fs1, x1, y1} !== 46'd0) begin
            n_bad++;
            $display("FAIL mid_reset_s1 got=%h exp=0",
                     {px_req0, ls0, fs0, x0, y0, px_req1, ls1, fs1, x1, y1});
        end
        rst = 1'b0;
        restart_model();
        ph = 1'b1;
        hfall = -1;
        for (int k = 0; k < FRAME + HTOTAL; k++) begin
            tick(s1_a, s1_e, p_a, p_e);
            n_cmp++;
            if ({s1_a, p_a} !== {s1_e, p_e}) begin
                n_bad++;
                $display("FAIL post_reset cyc=%0d got=%h exp=%h", k, {s1_a, p_a}, {s1_e, p_e});
            end
            if (ph && !p_a[11] && hfall < 0) begin
                hfall = k;
                n_cmp++;
                if (k !== 2 + H_FP) begin
                    n_bad++;
                    $display("FAIL restart_hsync got=%0d exp=%0d", k, 2 + H_FP);
                end
            end
            ph = p_a[11];
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        test_reset();
        test_timing();
        test_mid_frame_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator and pixel pipeline, successor to the fixed 640x480@72Hz controller. It runs on an externally supplied pixel clock, so the PLL lives at top level. It exposes all horizontal and vertical timings, colour depth and sync polarities as parameters. It issues pixel requests one cycle ahead so that pixel sources (framebuffer, sprite logic) have a full cycle to produce colour, and it emits sync, data-enable and colour aligned at the monitor pins.

## Interface
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 24: horizontal front porch (clocks).
- H_SYNC, 40: hsync pulse width (clocks).
- H_BP, 128: horizontal back porch (clocks).
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 9 / V_SYNC, 3 / V_BP, 28: vertical front porch / sync / back porch (lines).
- HS_POL, 0 / VS_POL, 0: sync active level; 0 = active-low.
- CW, 1: bits per colour channel.
- CNT_W, 10: counter and coordinate width. Must hold H_ACTIVE+H_FP+H_SYNC+H_BP-1 and the vertical equivalent.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- color_px  in  3*CW  colour for the pixel requested in the previous cycle, ordered {R,G,B}.
- x_px, y_px  out  CNT_W each  coordinates of the requested pixel.
- px_req  out  1  x_px/y_px are a visible pixel.
- line_start  out  1  one-cycle pulse with px_req at x_px=0.
- frame_start  out  1  one-cycle pulse with px_req at x_px=0, y_px=0.
- hsync, vsync  out  1  sync outputs, with polarity set by HS_POL/VS_POL.
- de  out  1  data enable at monitor pins.
- red, green, blue  out  CW each  monitor colour.

## Operation
- Derived constants: HBLANK=H_FP+H_SYNC+H_BP, HTOTAL=HBLANK+H_ACTIVE. VBLANK and VTOTAL are formed the same way.
- Line order is front porch, sync, back porch, then active. Frame order is the same.
- hc counts 0..HTOTAL-1 and wraps to 0.
- At the hc wrap, vc increments. vc wraps 0 after VTOTAL-1, so both wrap on the same edge.
- Raw decode from the counters:
  - hs_raw is active when H_FP ≤ hc < H_FP+H_SYNC.
  - vs_raw is active when V_FP ≤ vc < V_FP+V_SYNC.
  - vis is high when hc ≥ HBLANK and vc ≥ VBLANK.
- Stage S1 (registered from the counters):
  - px_req=vis.
  - When vis, x_px=hc-HBLANK and y_px=vc-VBLANK; otherwise both are 0.
  - line_start and frame_start are registered in S1.
  - hs_raw, vs_raw and vis are carried forward.
- Stage S2 (registered from S1):
  - hsync/vsync take the carried raw syncs, converted to the configured polarity.
  - de=S1 vis.
  - When de is high, {red,green,blue}=color_px; otherwise 0.
- Sync and colour leave the same register stage, so they never skew relative to each other.
- Reset drives every output to its inactive value:
  - x_px=0, y_px=0, px_req=0, line_start=0, frame_start=0, de=0, RGB=0.
  - hsync=~HS_POL, vsync=~VS_POL.
  - hc=vc=0, and all pipeline registers are cleared.
- Reset asserted mid-frame takes effect on the next edge and aborts the frame. No partial-line sync remains in the pipe.

## Timing
- Counter-to-pin latency is 2 clocks.
- color_px is sampled on the edge one clock after the matching x_px/y_px/px_req become valid. The source has one full clock period of combinational or registered lookup.
- Line period is HTOTAL clocks; default 832. Frame period is HTOTAL*VTOTAL clocks; default 832*520=432640.
- After rst falls, the first cycle has hc=0. hsync first goes active 2+H_FP clocks after release.
- px_req first rises when hc=HBLANK and vc=VBLANK. frame_start pulses on that cycle.
- With defaults, de is high for 640 consecutive clocks per active line and for 480 lines per frame.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - Adds input port pattern_en (1 bit).
  - While pattern_en=1, color_px is ignored and S2 outputs 8 vertical colour bars.
  - bar = x / (H_ACTIVE/8), where x is the pixel's x_px; H_ACTIVE must be a multiple of 8.
  - Channels are red=all-ones×bar[2], green=all-ones×bar[1], blue=all-ones×bar[0].
  - The pattern obeys the same 2-clock alignment and de gating as normal colour.
- VGA_TEST_PATTERN_EN undefined: the pattern_en port and the bar logic are absent, and colour always comes from color_px.

## Test plan
- Reset: hold rst 5 clocks → all outputs at reset values, hsync=vsync=1 (defaults). Release → hsync falls exactly 26 clocks later and stays low 40 clocks.
- Line/frame period: run 2 frames → hsync period 832, vsync low for 3×832 clocks with period 432640, de high for 640 clocks per line on 480 lines.
- Alignment: drive color_px={x_px[2:0]} registered one clock after the request → each de-high pixel on RGB equals its x coordinate mod 8. RGB=0 whenever de=0.
- Markers: frame_start pulses once per frame, with x_px=y_px=0. line_start pulses 480 times per frame.
- Mid-frame reset: assert rst for 1 clock at vc=300 → next cycle outputs are at reset values. Timing restarts from hc=vc=0 with no short hsync pulse.
- Parameters/pattern: HS_POL=1, VS_POL=1, H_ACTIVE=64, V_ACTIVE=8 → hsync idles low and pulses high. With VGA_TEST_PATTERN_EN and pattern_en=1, RGB steps through 000..111 every 8 pixels.
